// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg
// Shared types and helpers for the Wishbone N:1 round-robin arbiter.
//   arb_state_e : arbiter FSM state encoding (IDLE, BUSY, TOUT)
//   idx_width   : bits needed to hold a master index, never less than 1
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    TOUT = 2'd2
  } arb_state_e;

  function automatic int idx_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wb_arb_rr_pick.sv
// wb_arb_rr_pick
// Combinational round-robin selector: returns the first asserted request at
// or after ptr, scanning upward and wrapping modulo N_MASTERS.
// Ports:
//   req   in  N_MASTERS  request vector
//   ptr   in  IW         scan start index
//   valid out 1          any request present
//   pick  out N_MASTERS  one-hot winner
//   idx   out IW         winner index
module wb_arb_rr_pick
  import wb_arb_pkg::*;
#(
  parameter int N_MASTERS = 3,
  parameter int IW        = idx_width(N_MASTERS)
) (
  input  logic [N_MASTERS-1:0] req,
  input  logic [IW-1:0]        ptr,
  output logic                 valid,
  output logic [N_MASTERS-1:0] pick,
  output logic [IW-1:0]        idx
);

  // Scan from the farthest offset down to offset 0 so the nearest
  // requester after ptr overwrites any farther one.
  always_comb begin
    int j;
    j     = 0;
    valid = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = N_MASTERS - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N_MASTERS;
      if (req[j]) begin
        valid   = 1'b1;
        pick    = '0;
        pick[j] = 1'b1;
        idx     = IW'(j);
      end
    end
  end

endmodule

// File: rtl/wb_arbiter_nx1.sv
// wb_arbiter_nx1
// Round-robin arbiter sharing one Wishbone slave port among N_MASTERS
// masters. Ownership is held for the whole CYC period of the winner.
// Optional watchdog (macro WB_ARB_TIMEOUT_EN) ends stalled strobes with ERR.
// Ports:
//   clk, rstn                      clock, async active-low reset
//   ADR/CTI/BTE/DAT_W/SEL/CYC/STB/WE  per-master request (unpacked arrays)
//   DAT_R, ACK, ERR                per-master response
//   SADR/SCTI/SBTE/SDAT_W/SSEL/SCYC/SSTB/SWE  to slave
//   SDAT_R, SACK, SERR             from slave
//   gnt                            one-hot owner, zero when idle
//
// state | meaning
// IDLE  | no owner, slave outputs zero, arbitrate on CYC
// BUSY  | owner's request forwarded, slave response routed to owner
// TOUT  | watchdog fired: slave cycle dropped, one-cycle ERR to owner
module wb_arbiter_nx1
  import wb_arb_pkg::*;
#(
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int WB_DATA_WIDTH  = 32,
  parameter int N_MASTERS      = 3,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [WB_ADDR_WIDTH-1:0] ADR    [N_MASTERS-1:0],
  input  logic [2:0]               CTI    [N_MASTERS-1:0],
  input  logic [1:0]               BTE    [N_MASTERS-1:0],
  input  logic [WB_DATA_WIDTH-1:0] DAT_W  [N_MASTERS-1:0],
  input  logic [WB_DATA_WIDTH/8-1:0] SEL  [N_MASTERS-1:0],
  input  logic                     CYC    [N_MASTERS-1:0],
  input  logic                     STB    [N_MASTERS-1:0],
  input  logic                     WE     [N_MASTERS-1:0],
  output logic [WB_DATA_WIDTH-1:0] DAT_R  [N_MASTERS-1:0],
  output logic [N_MASTERS-1:0]     ACK,
  output logic [N_MASTERS-1:0]     ERR,
  output logic [WB_ADDR_WIDTH-1:0] SADR,
  output logic [2:0]               SCTI,
  output logic [1:0]               SBTE,
  output logic [WB_DATA_WIDTH-1:0] SDAT_W,
  output logic [WB_DATA_WIDTH/8-1:0] SSEL,
  output logic                     SCYC,
  output logic                     SSTB,
  output logic                     SWE,
  input  logic [WB_DATA_WIDTH-1:0] SDAT_R,
  input  logic                     SACK,
  input  logic                     SERR,
  output logic [N_MASTERS-1:0]     gnt
);

  localparam int IW = idx_width(N_MASTERS);

  if (N_MASTERS < 2 || N_MASTERS > 8) begin : g_bad_n
    $error("wb_arbiter_nx1: N_MASTERS must be 2..8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_tout
    $error("wb_arbiter_nx1: TIMEOUT_CYCLES must be >= 1");
  end

  arb_state_e           r_state, w_state_nx;
  logic [IW-1:0]        r_owner, w_owner_nx;
  logic [IW-1:0]        r_ptr, w_ptr_nx, w_ptr_inc;
  logic [N_MASTERS-1:0] r_gnt, w_gnt_nx;
  logic [N_MASTERS-1:0] w_req;
  logic                 w_pick_valid;
  logic [N_MASTERS-1:0] w_pick_oh;
  logic [IW-1:0]        w_pick_idx;
  logic                 w_own_cyc, w_own_stb;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt, w_cnt_nx;
`endif

  always_comb begin
    w_req = '0;
    for (int i = 0; i < N_MASTERS; i++) w_req[i] = CYC[i];
  end

  assign w_own_cyc = CYC[r_owner];
  assign w_own_stb = STB[r_owner];
  assign w_ptr_inc = (r_owner == IW'(N_MASTERS - 1)) ? '0 : r_owner + 1'b1;

  wb_arb_rr_pick #(
    .N_MASTERS (N_MASTERS),
    .IW        (IW)
  ) u_pick (
    .req   (w_req),
    .ptr   (r_ptr),
    .valid (w_pick_valid),
    .pick  (w_pick_oh),
    .idx   (w_pick_idx)
  );

  always_comb begin
    w_state_nx = r_state;
    w_owner_nx = r_owner;
    w_gnt_nx   = r_gnt;
    w_ptr_nx   = r_ptr;
`ifdef WB_ARB_TIMEOUT_EN
    w_cnt_nx   = '0;
`endif
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_state_nx = BUSY;
          w_owner_nx = w_pick_idx;
          w_gnt_nx   = w_pick_oh;
        end
      end
      BUSY: begin
        // Release on CYC drop even with an unacknowledged strobe pending.
        if (!w_own_cyc) begin
          w_state_nx = IDLE;
          w_gnt_nx   = '0;
          w_ptr_nx   = w_ptr_inc;
        end
`ifdef WB_ARB_TIMEOUT_EN
        else if (SACK || SERR) begin
          w_cnt_nx = '0;
        end else if (r_cnt == CW'(TIMEOUT_CYCLES)) begin
          w_state_nx = TOUT;
        end else if (w_own_stb) begin
          w_cnt_nx = r_cnt + 1'b1;
        end else begin
          w_cnt_nx = r_cnt;
        end
`endif
      end
`ifdef WB_ARB_TIMEOUT_EN
      TOUT: begin
        if (!w_own_cyc) begin
          w_state_nx = IDLE;
          w_gnt_nx   = '0;
          w_ptr_nx   = w_ptr_inc;
        end else begin
          w_state_nx = BUSY;
        end
      end
`endif
      default: begin
        w_state_nx = IDLE;
        w_gnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_gnt   <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_owner <= w_owner_nx;
      r_gnt   <= w_gnt_nx;
      r_ptr   <= w_ptr_nx;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_cnt <= '0;
    else       r_cnt <= w_cnt_nx;
  end
`endif

  // All slave/master outputs derive from registered state, so an async reset
  // zeroes them immediately.
  always_comb begin
    SADR   = '0;
    SCTI   = '0;
    SBTE   = '0;
    SDAT_W = '0;
    SSEL   = '0;
    SCYC   = 1'b0;
    SSTB   = 1'b0;
    SWE    = 1'b0;
    ACK    = '0;
    ERR    = '0;
    if (r_state == BUSY) begin
      SADR         = ADR[r_owner];
      SCTI         = CTI[r_owner];
      SBTE         = BTE[r_owner];
      SDAT_W       = DAT_W[r_owner];
      SSEL         = SEL[r_owner];
      SCYC         = CYC[r_owner];
      SSTB         = STB[r_owner];
      SWE          = WE[r_owner];
      ACK[r_owner] = SACK;
      ERR[r_owner] = SERR;
    end
`ifdef WB_ARB_TIMEOUT_EN
    else if (r_state == TOUT) begin
      SADR         = ADR[r_owner];
      SCTI         = CTI[r_owner];
      SBTE         = BTE[r_owner];
      SDAT_W       = DAT_W[r_owner];
      SSEL         = SEL[r_owner];
      ERR[r_owner] = 1'b1;
    end
`endif
  end

  for (genvar i = 0; i < N_MASTERS; i++) begin : g_datr
    assign DAT_R[i] = SDAT_R;
  end

  assign gnt = r_gnt;

endmodule

// File: tb/tb_wb_arbiter_nx1.sv
module tb_wb_arbiter_nx1;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [AW-1:0] ADR   [N-1:0];
  logic [2:0]    CTI   [N-1:0];
  logic [1:0]    BTE   [N-1:0];
  logic [DW-1:0] DAT_W [N-1:0];
  logic [SW-1:0] SEL   [N-1:0];
  logic          CYC   [N-1:0];
  logic          STB   [N-1:0];
  logic          WE    [N-1:0];
  logic [DW-1:0] DAT_R [N-1:0];
  logic [N-1:0]  ACK, ERR, gnt;
  logic [AW-1:0] SADR;
  logic [2:0]    SCTI;
  logic [1:0]    SBTE;
  logic [DW-1:0] SDAT_W, SDAT_R;
  logic [SW-1:0] SSEL;
  logic          SCYC, SSTB, SWE, SACK, SERR;

  wb_arbiter_nx1 #(
    .WB_ADDR_WIDTH(AW), .WB_DATA_WIDTH(DW), .N_MASTERS(N), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rstn(rstn),
    .ADR(ADR), .CTI(CTI), .BTE(BTE), .DAT_W(DAT_W), .SEL(SEL),
    .CYC(CYC), .STB(STB), .WE(WE),
    .DAT_R(DAT_R), .ACK(ACK), .ERR(ERR),
    .SADR(SADR), .SCTI(SCTI), .SBTE(SBTE), .SDAT_W(SDAT_W), .SSEL(SSEL),
    .SCYC(SCYC), .SSTB(SSTB), .SWE(SWE),
    .SDAT_R(SDAT_R), .SACK(SACK), .SERR(SERR),
    .gnt(gnt)
  );

  int n_chk, n_err;

  // reference model: current owner (-1 = none), next scan start,
  // consecutive stalled strobe cycles, and a pending timeout-error cycle
  int m_owner, m_ptr, m_stall;
  bit m_tout;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_stall = 0;
    m_tout  = 0;
  endtask

  task automatic check_outputs();
    logic [N-1:0] e_gnt, e_ack, e_err;
    logic e_cyc, e_stb, e_we;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_dat;
    logic [SW-1:0] e_sel;
    logic [2:0] e_cti;
    logic [1:0] e_bte;
    bit fwd;
    e_gnt = '0; e_ack = '0; e_err = '0;
    e_cyc = 0; e_stb = 0; e_we = 0;
    e_adr = '0; e_dat = '0; e_sel = '0; e_cti = '0; e_bte = '0;
    fwd = 1;
    if (m_owner >= 0) begin
      e_gnt[m_owner] = 1'b1;
      if (m_tout) begin
        e_err[m_owner] = 1'b1;
        fwd = 0;
      end else begin
        e_cyc = CYC[m_owner]; e_stb = STB[m_owner]; e_we = WE[m_owner];
        e_adr = ADR[m_owner]; e_dat = DAT_W[m_owner]; e_sel = SEL[m_owner];
        e_cti = CTI[m_owner]; e_bte = BTE[m_owner];
        e_ack[m_owner] = SACK;
        e_err[m_owner] = SERR;
      end
    end
    check_val("gnt", gnt, e_gnt);
    check_val("scyc", SCYC, e_cyc);
    check_val("sstb", SSTB, e_stb);
    check_val("ack", ACK, e_ack);
    check_val("err", ERR, e_err);
    if (fwd) begin
      check_val("swe", SWE, e_we);
      check_val("sadr", SADR, e_adr);
      check_val("sdatw", SDAT_W, e_dat);
      check_val("ssel", SSEL, e_sel);
      check_val("scti", SCTI, e_cti);
      check_val("sbte", SBTE, e_bte);
    end
    for (int i = 0; i < N; i++) check_val("datr", DAT_R[i], SDAT_R);
  endtask

  // what the arbiter decides at the coming rising edge
  task automatic model_edge();
    bit found;
    if (m_owner < 0) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && CYC[(m_ptr + k) % N]) begin
          m_owner = (m_ptr + k) % N;
          m_stall = 0;
          found   = 1;
        end
      end
    end else if (!CYC[m_owner]) begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
      m_tout  = 0;
      m_stall = 0;
    end else if (m_tout) begin
      m_tout = 0;
    end else begin
`ifdef WB_ARB_TIMEOUT_EN
      if (SACK || SERR) m_stall = 0;
      else if (m_stall == TO) begin
        m_tout  = 1;
        m_stall = 0;
      end else if (STB[m_owner]) m_stall++;
`endif
    end
  endtask

  // called at a falling edge with inputs already driven
  task automatic step();
    #1;
    check_outputs();
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_all();
    for (int i = 0; i < N; i++) begin
      ADR[i] = '0; CTI[i] = '0; BTE[i] = '0; DAT_W[i] = '0; SEL[i] = '0;
      CYC[i] = 0; STB[i] = 0; WE[i] = 0;
    end
    SDAT_R = '0; SACK = 0; SERR = 0;
  endtask

  task automatic do_reset();
    #1 rstn = 1'b0;
    #1;
    check_val("rst_scyc", SCYC, 0);
    check_val("rst_gnt", gnt, 0);
    check_val("rst_ack", ACK, 0);
    @(negedge clk);
    idle_all();
    rstn = 1'b1;
    model_reset();
  endtask

  initial begin
    int seq[$];
    int gaps[$];
    int gap, k;
    bit drop[N];
    bit found;
    logic [N-1:0] g;
    logic sack_v;
    int hold[N];
    int r;

    n_chk = 0; n_err = 0;
    model_reset();
    idle_all();
    rstn = 1'b1;
    for (int i = 0; i < N; i++) begin CYC[i] = 1; STB[i] = 1; end
    SACK = 1;
    @(negedge clk);
    do_reset();
    step(); step();

    // single write from m0
    CYC[0] = 1; STB[0] = 1; WE[0] = 1; ADR[0] = 32'h1000; DAT_W[0] = 32'hDEADBEEF; SEL[0] = 4'hF;
    #1 check_val("single_pre", SCYC, 0);
    step();
    SACK = 1; SDAT_R = 32'h12345678;
    #1;
    check_val("single_scyc", SCYC, 1);
    check_val("single_sadr", SADR, 32'h1000);
    check_val("single_sdat", SDAT_W, 32'hDEADBEEF);
    check_val("single_ack", ACK, 3'b001);
    step();
    SACK = 0; CYC[0] = 0; STB[0] = 0; WE[0] = 0;
    step(); step();

    // round robin from reset: each master does one transfer and re-requests
    do_reset();
    for (int i = 0; i < N; i++) drop[i] = 0;
    gap = 0;
    for (int c = 0; c < 60 && seq.size() < 6; c++) begin
      for (int i = 0; i < N; i++) begin
        CYC[i] = !drop[i]; STB[i] = !drop[i]; ADR[i] = 32'(i * 16);
      end
      g = gnt;
      sack_v = 0;
      for (int i = 0; i < N; i++) if (g[i] && CYC[i]) sack_v = 1;
      SACK = sack_v;
      if (g == '0) gap++;
      else if (sack_v) begin
        for (int i = 0; i < N; i++) if (g[i]) seq.push_back(i);
        gaps.push_back(gap);
        gap = 0;
      end
      step();
      for (int i = 0; i < N; i++) drop[i] = g[i] && sack_v;
    end
    check_val("rr_count", seq.size(), 6);
    for (int i = 0; i < seq.size(); i++) begin
      check_val("rr_order", seq[i], i % N);
      if (i > 0) check_val("rr_gap", gaps[i], 1);
    end
    idle_all();
    step(); step();

    // lock: m0 keeps CYC across 4 acks while m1 waits
    CYC[0] = 1; STB[0] = 1; CYC[1] = 1; STB[1] = 1; ADR[1] = 32'h2000;
    step();
    for (int i = 0; i < 4; i++) begin
      SACK = 1; SDAT_R = $urandom;
      #1 check_val("lock_gnt", gnt, 3'b001);
      step();
    end
    SACK = 0; CYC[0] = 0; STB[0] = 0;
    step();
    #1 check_val("lock_gap", gnt, 3'b000);
    step();
    #1 check_val("lock_hand", gnt, 3'b010);

    // abandon: m1 drops CYC with its strobe unacknowledged
    step(); step();
    CYC[1] = 0; STB[1] = 0;
    step();
    CYC[0] = 1; CYC[2] = 1;
    #1;
    check_val("abn_scyc", SCYC, 0);
    check_val("abn_ack", ACK, 0);
    step();
    #1 check_val("abn_ptr", gnt, 3'b100);
    idle_all();
    step(); step();

`ifdef WB_ARB_TIMEOUT_EN
    // watchdog: slave never answers m2
    CYC[2] = 1; STB[2] = 1; ADR[2] = 32'h3000;
    step();
    k = 0; found = 0;
    for (int t = 0; t < 30 && !found; t++) begin
      #1;
      if (ERR[2]) found = 1;
      else begin
        step();
        k++;
      end
    end
    check_val("tout_seen", found, 1);
    check_val("tout_lat", k, TO + 1);
    check_val("tout_sstb", SSTB, 0);
    step();
    #1;
    check_val("tout_pulse", ERR, 0);
    check_val("tout_fwd", SSTB, 1);
    step();
`else
    // no watchdog: a stalled slave keeps the bus
    CYC[2] = 1; STB[2] = 1; ADR[2] = 32'h3000;
    for (int t = 0; t < 20; t++) step();
    #1;
    check_val("stall_gnt", gnt, 3'b100);
    check_val("stall_err", ERR, 0);
`endif
    idle_all();
    step(); step();

    // reset in the middle of m0's burst
    CYC[0] = 1; STB[0] = 1;
    step();
    step();
    SACK = 1;
    #1 check_val("rmb_ack", ACK, 3'b001);
    #1 rstn = 1'b0;
    #1;
    check_val("rmb_scyc", SCYC, 0);
    check_val("rmb_gnt", gnt, 0);
    check_val("rmb_ackz", ACK, 0);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    idle_all();
    CYC[1] = 1; CYC[2] = 1;
    step();
    #1 check_val("rmb_regrant", gnt, 3'b010);
    idle_all();
    step(); step();

    // randomized traffic against the model
    for (int i = 0; i < N; i++) hold[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (hold[i] == 0) begin
          CYC[i] = !CYC[i];
          hold[i] = $urandom_range(12, 1);
        end
        hold[i]--;
        STB[i]   = CYC[i] & 1'($urandom_range(1, 0));
        WE[i]    = 1'($urandom_range(1, 0));
        ADR[i]   = $urandom;
        DAT_W[i] = $urandom;
        SEL[i]   = 4'($urandom_range(15, 0));
        CTI[i]   = 3'($urandom_range(7, 0));
        BTE[i]   = 2'($urandom_range(3, 0));
      end
      r = $urandom_range(7, 0);
      SACK   = (r < 3);
      SERR   = (r == 3);
      SDAT_R = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
